stone_ram_arbiter: RTL

//  Shares the single-port stone RAM between the stone renderer (draw port, read-only) and the

---
 rtl/stone_ram_arbiter.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/stone_ram_arbiter.sv
// ---------------------------------------------------------------------------
// stone_ram_arbiter
//
// Purpose:
//   Shares the single-port stone RAM between two clients. The stone renderer
//   uses the draw port, which is read-only. The rope controller uses the rope
//   port, which can read and write. Only one RAM access is in flight at a time.
//   Draw has fixed priority. A saturating wait counter lets the rope port win
//   once it has lost MAX_WAIT arbitrations in a row, so rope is never starved.
//
// Ports:
//   clock, resetn         system clock, asynchronous active-low reset
//   draw_req/draw_addr    renderer read request (held until draw_gnt)
//   draw_gnt              one-cycle pulse, draw access issued this cycle
//   draw_rvalid/rdata     draw read data return (rdata holds until next read)
//   rope_req/we/addr/wdata rope request (held until rope_gnt)
//   rope_gnt              one-cycle pulse, rope access issued this cycle
//   rope_rvalid/rdata     rope read data return (reads only)
//   ram_address/data/wren RAM command, all registered
//   ram_q                 RAM read data, valid RD_LAT cycles after address
//   busy                  1 whenever the arbiter is not idle
// ---------------------------------------------------------------------------
module stone_ram_arbiter #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              draw_req,
    input  logic [ADDR_W-1:0] draw_addr,
    output logic              draw_gnt,
    output logic              draw_rvalid,
    output logic [DATA_W-1:0] draw_rdata,
    input  logic              rope_req,
    input  logic              rope_we,
    input  logic [ADDR_W-1:0] rope_addr,
    input  logic [DATA_W-1:0] rope_wdata,
    output logic              rope_gnt,
    output logic              rope_rvalid,
    output logic [DATA_W-1:0] rope_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy
);

    localparam int WC_W  = $clog2(MAX_WAIT + 1);
    localparam int LAT_W = $clog2(RD_LAT + 1);
    localparam logic [WC_W-1:0]  MAX_WAIT_C = WC_W'(MAX_WAIT);
    // S_WAIT lasts RD_LAT-1 cycles: load RD_LAT-2 and leave when the count reaches zero.
    localparam logic [LAT_W-1:0] LAT_INIT   = LAT_W'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RETURN = 2'd3
    } state_t;

    state_t              state_q,       state_d;
    logic                owner_rope_q,  owner_rope_d;   // 1 = current access belongs to rope
    logic                is_write_q,    is_write_d;
    logic [WC_W-1:0]     wait_cnt_q,    wait_cnt_d;
    logic [LAT_W-1:0]    lat_cnt_q,     lat_cnt_d;
    logic                draw_gnt_q,    draw_gnt_d;
    logic                rope_gnt_q,    rope_gnt_d;
    logic                draw_rvalid_q, draw_rvalid_d;
    logic                rope_rvalid_q, rope_rvalid_d;
    logic [DATA_W-1:0]   draw_rdata_q,  draw_rdata_d;
    logic [DATA_W-1:0]   rope_rdata_q,  rope_rdata_d;
    logic [ADDR_W-1:0]   ram_address_q, ram_address_d;
    logic [DATA_W-1:0]   ram_data_q,    ram_data_d;
    logic                ram_wren_q,    ram_wren_d;
    logic                busy_q,        busy_d;

    logic                rope_win;
    logic                draw_win;
    logic                enter_return;

    always_comb begin
        state_d       = state_q;
        owner_rope_d  = owner_rope_q;
        is_write_d    = is_write_q;
        wait_cnt_d    = wait_cnt_q;
        lat_cnt_d     = lat_cnt_q;
        draw_rdata_d  = draw_rdata_q;
        rope_rdata_d  = rope_rdata_q;
        ram_address_d = ram_address_q;
        ram_data_d    = ram_data_q;
        // Pulse outputs default low every cycle.
        draw_gnt_d    = 1'b0;
        rope_gnt_d    = 1'b0;
        draw_rvalid_d = 1'b0;
        rope_rvalid_d = 1'b0;
        ram_wren_d    = 1'b0;
        rope_win      = 1'b0;
        draw_win      = 1'b0;
        enter_return  = 1'b0;

        case (state_q)
            S_IDLE: begin
                rope_win = rope_req && (!draw_req || (wait_cnt_q >= MAX_WAIT_C));
                draw_win = !rope_win && draw_req;
                if (rope_win) begin
                    state_d       = S_ACCESS;
                    owner_rope_d  = 1'b1;
                    is_write_d    = rope_we;
                    ram_address_d = rope_addr;
                    ram_data_d    = rope_wdata;
                    ram_wren_d    = rope_we;
                    rope_gnt_d    = 1'b1;
                    wait_cnt_d    = '0;
                end else if (draw_win) begin
                    state_d       = S_ACCESS;
                    owner_rope_d  = 1'b0;
                    is_write_d    = 1'b0;
                    ram_address_d = draw_addr;
                    draw_gnt_d    = 1'b1;
                    // Rope lost this round; count it, saturating at MAX_WAIT.
                    if (rope_req && (wait_cnt_q != MAX_WAIT_C)) begin
                        wait_cnt_d = wait_cnt_q + WC_W'(1);
                    end
                end
                if (!rope_req) begin
                    wait_cnt_d = '0;
                end
            end

            S_ACCESS: begin
                if (is_write_q) begin
                    state_d = S_IDLE;
                end else if (RD_LAT == 1) begin
                    enter_return = 1'b1;
                end else begin
                    state_d   = S_WAIT;
                    lat_cnt_d = LAT_INIT;
                end
            end

            S_WAIT: begin
                if (lat_cnt_q == '0) begin
                    enter_return = 1'b1;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end

            S_RETURN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // ram_q is captured on the edge that enters S_RETURN, so rvalid and rdata
        // appear together in the single S_RETURN cycle.
        if (enter_return) begin
            state_d = S_RETURN;
            if (owner_rope_q) begin
                rope_rdata_d  = ram_q;
                rope_rvalid_d = 1'b1;
            end else begin
                draw_rdata_d  = ram_q;
                draw_rvalid_d = 1'b1;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    // Asynchronous reset drops any in-flight read: the state returns to idle,
    // so its rvalid can never be produced.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            owner_rope_q  <= 1'b0;
            is_write_q    <= 1'b0;
            wait_cnt_q    <= '0;
            lat_cnt_q     <= '0;
            draw_gnt_q    <= 1'b0;
            rope_gnt_q    <= 1'b0;
            draw_rvalid_q <= 1'b0;
            rope_rvalid_q <= 1'b0;
            draw_rdata_q  <= '0;
            rope_rdata_q  <= '0;
            ram_address_q <= '0;
            ram_data_q    <= '0;
            ram_wren_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_rope_q  <= owner_rope_d;
            is_write_q    <= is_write_d;
            wait_cnt_q    <= wait_cnt_d;
            lat_cnt_q     <= lat_cnt_d;
            draw_gnt_q    <= draw_gnt_d;
            rope_gnt_q    <= rope_gnt_d;
            draw_rvalid_q <= draw_rvalid_d;
            rope_rvalid_q <= rope_rvalid_d;
            draw_rdata_q  <= draw_rdata_d;
            rope_rdata_q  <= rope_rdata_d;
            ram_address_q <= ram_address_d;
            ram_data_q    <= ram_data_d;
            ram_wren_q    <= ram_wren_d;
            busy_q        <= busy_d;
        end
    end

    assign draw_gnt    = draw_gnt_q;
    assign draw_rvalid = draw_rvalid_q;
    assign draw_rdata  = draw_rdata_q;
    assign rope_gnt    = rope_gnt_q;
    assign rope_rvalid = rope_rvalid_q;
    assign rope_rdata  = rope_rdata_q;
    assign ram_address = ram_address_q;
    assign ram_data    = ram_data_q;
    assign ram_wren    = ram_wren_q;
    assign busy        = busy_q;

endmodule
